// File: rtl/sar_result_avg_if.sv
// SAR sample input plus averaged-result stream with valid/ready handshake.
// The averager uses the slave view; whoever drives the SAR and consumes results uses master.
interface sar_result_avg_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] bitout;
  logic              conv_done;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output bitout, conv_done, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  bitout, conv_done, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/sar_result_avg.sv
// Averages 2^avg_log2 SAR conversions per window and queues the truncated
// means in a small FIFO with a sticky overflow flag for dropped results.
module sar_result_avg #(
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic [1:0]                  avg_log2,
  input  logic                        clr_ovf,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  sar_result_avg_if.slave             bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = DATA_W + 3;

  logic              conv_done_q;
  logic [2:0]        cnt;
  logic [1:0]        k;
  logic [AW-1:0]     acc;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  logic              capture;
  logic [1:0]        win_k;
  logic [2:0]        last_idx;
  logic              is_final;
  logic [AW-1:0]     sum;
  logic [DATA_W-1:0] result;
  logic              full;
  logic              pop;
  logic              wr_en;
  logic              drop;

  // The first capture of a window uses the live avg_log2; later ones use the latched k.
  assign capture  = en & bus.conv_done & ~conv_done_q;
  assign win_k    = (cnt == 3'd0) ? avg_log2 : k;
  assign last_idx = 3'((4'd1 << win_k) - 4'd1);
  assign is_final = capture && (cnt == last_idx);
  assign sum      = acc + AW'(bus.bitout);
  assign result   = DATA_W'(sum >> win_k);

  assign full  = (fifo_count == CW'(FIFO_DEPTH));
  assign pop   = bus.out_valid & bus.out_ready;
  assign wr_en = is_final & (~full | pop);
  assign drop  = is_final & full & ~pop;

  assign bus.out_valid = (fifo_count != '0);
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      conv_done_q <= 1'b1;
      cnt         <= '0;
      k           <= '0;
      acc         <= '0;
    end else begin
      conv_done_q <= bus.conv_done;
      if (!en) begin
        cnt <= '0;
        acc <= '0;
      end else if (capture) begin
        if (cnt == 3'd0) k <= avg_log2;
        if (is_final) begin
          cnt <= '0;
          acc <= '0;
        end else begin
          cnt <= cnt + 3'd1;
          acc <= sum;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      // A drop on the same edge as clr_ovf wins.
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // NOTE: storage is deliberately not reset; entries are only visible once
  // written, and out_data is forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= result;
  end

endmodule

// File: tb/tb_sar_result_avg.sv
// Randomized and directed bench for sar_result_avg against a queue-based
// model of the averaging window and the result FIFO.
module tb_sar_result_avg;

  localparam int DW    = 12;
  localparam int DEPTH = 4;

  logic                   clk;
  logic                   reset;
  logic                   en;
  logic [1:0]             avg_log2;
  logic                   clr_ovf;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   overflow;

  sar_result_avg_if #(.DATA_W(DW)) bus ();

  sar_result_avg #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .avg_log2   (avg_log2),
    .clr_ovf    (clr_ovf),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a window is a list of samples; its mean is sum / N once N samples are in.
  logic [DW-1:0] m_fifo [$];
  int unsigned   m_win  [$];
  int unsigned   m_n;
  bit            m_ovf;
  bit            m_prev;

  always @(posedge clk) begin : model
    bit            do_pop;
    bit            cap;
    bit            do_push;
    logic [DW-1:0] res;
    int unsigned   s;
    if (reset) begin
      m_fifo.delete();
      m_win.delete();
      m_n    = 1;
      m_ovf  = 1'b0;
      m_prev = 1'b1;
    end else begin
      do_pop  = (m_fifo.size() != 0) && bus.out_ready;
      cap     = bus.conv_done && !m_prev && en;
      do_push = 1'b0;
      res     = '0;
      if (!en) begin
        m_win.delete();
      end else if (cap) begin
        if (m_win.size() == 0) m_n = 1 << avg_log2;
        m_win.push_back(int'(bus.bitout));
        if (m_win.size() == m_n) begin
          s = 0;
          foreach (m_win[i]) s += m_win[i];
          res     = DW'(s / m_n);
          do_push = 1'b1;
          m_win.delete();
        end
      end
      if (do_push && m_fifo.size() == DEPTH && !do_pop) m_ovf = 1'b1;
      else if (clr_ovf)                                 m_ovf = 1'b0;
      if (do_pop) void'(m_fifo.pop_front());
      if (do_push && m_fifo.size() < DEPTH) m_fifo.push_back(res);
      m_prev = bus.conv_done;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("out_valid", 32'(bus.out_valid), 32'(m_fifo.size() != 0));
      check("fifo_count", 32'(fifo_count), 32'(m_fifo.size()));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (m_fifo.size() != 0) check("out_data", 32'(bus.out_data), 32'(m_fifo[0]));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic conv(input logic [DW-1:0] v, input int high);
    bus.bitout    = v;
    bus.conv_done = 1'b1;
    repeat (high) cycle();
    bus.conv_done = 1'b0;
    cycle();
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    repeat (DEPTH + 2) cycle();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    en            = 1'b1;
    avg_log2      = 2'd0;
    clr_ovf       = 1'b0;
    bus.bitout    = '0;
    bus.conv_done = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
    checking = 1'b1;
    repeat (2) cycle();

    // Reset state; conv_done already high at release must not capture.
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    repeat (3) cycle();
    check("no_spurious_capture", 32'(fifo_count), 32'd0);
    bus.conv_done = 1'b0;
    cycle();

    // Pass-through with N=1 and one-cycle latency.
    bus.bitout    = 12'hABC;
    bus.conv_done = 1'b1;
    check("pt_valid_before", 32'(bus.out_valid), 32'd0);
    cycle();
    check("pt_valid", 32'(bus.out_valid), 32'd1);
    check("pt_data", 32'(bus.out_data), 32'hABC);
    check("pt_count", 32'(fifo_count), 32'd1);
    bus.conv_done = 1'b0;
    cycle();
    check("pt_valid_after", 32'(bus.out_valid), 32'd0);
    check("pt_count_after", 32'(fifo_count), 32'd0);

    // Four-sample average with truncation.
    bus.out_ready = 1'b0;
    avg_log2      = 2'd2;
    conv(12'h100, 1);
    conv(12'h101, 1);
    conv(12'h102, 1);
    check("avg4_no_early_push", 32'(fifo_count), 32'd0);
    conv(12'h105, 1);
    check("avg4_count", 32'(fifo_count), 32'd1);
    check("avg4_data", 32'(bus.out_data), 32'h102);
    drain();

    // Overflow: six results into a four-entry FIFO.
    avg_log2 = 2'd0;
    for (int i = 1; i <= 6; i++) conv(DW'(i), 1);
    check("ovf_count", 32'(fifo_count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check("ovf_pop_order", 32'(bus.out_data), 32'(i));
      bus.out_ready = 1'b1;
      cycle();
      bus.out_ready = 1'b0;
    end
    check("ovf_empty", 32'(fifo_count), 32'd0);
    check("ovf_still_set", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    cycle();
    clr_ovf = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO: push and pop on the same edge.
    for (int i = 10; i <= 13; i++) conv(DW'(i), 1);
    check("full_count", 32'(fifo_count), 32'd4);
    bus.bitout    = 12'd14;
    bus.conv_done = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
    check("full_pp_count", 32'(fifo_count), 32'd4);
    check("full_pp_ovf", 32'(overflow), 32'd0);
    check("full_pp_head", 32'(bus.out_data), 32'd11);
    bus.out_ready = 1'b0;
    bus.conv_done = 1'b0;
    cycle();
    drain();

    // Long conv_done pulse captures once; reset while high blocks capture.
    conv(12'h055, 10);
    check("long_pulse_count", 32'(fifo_count), 32'd1);
    check("long_pulse_data", 32'(bus.out_data), 32'h055);
    drain();
    bus.bitout    = 12'h066;
    bus.conv_done = 1'b1;
    cycle();
    check("pre_reset_capture", 32'(fifo_count), 32'd1);
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    repeat (3) cycle();
    check("reset_high_no_capture", 32'(fifo_count), 32'd0);
    bus.conv_done = 1'b0;
    cycle();
    conv(12'h077, 1);
    check("after_reset_data", 32'(bus.out_data), 32'h077);
    drain();

    // Reset mid-window discards the partial sum.
    avg_log2 = 2'd3;
    for (int i = 0; i < 5; i++) conv(DW'($urandom_range(0, 4095)), 1);
    check("partial_window_count", 32'(fifo_count), 32'd0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    for (int i = 0; i < 8; i++) conv(12'hFFF, 1);
    check("avg8_count", 32'(fifo_count), 32'd1);
    check("avg8_data", 32'(bus.out_data), 32'hFFF);
    drain();

    // Random traffic, including mid-window avg_log2 changes, en drops and resets.
    for (int seg = 0; seg < 6; seg++) begin
      for (int c = 0; c < 500; c++) begin
        reset = ($urandom_range(0, 299) == 0);
        en    = ($urandom_range(0, 15) != 0);
        if ($urandom_range(0, 19) == 0) avg_log2 = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 2) == 0) bus.conv_done = ~bus.conv_done;
        bus.bitout    = DW'($urandom_range(0, 4095));
        bus.out_ready = (seg % 2 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
        clr_ovf       = ($urandom_range(0, 9) == 0);
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sar_result_avg.md
SAR_RESULT_AVG -- requirements
Module: sar_result_avg

Interface
REQ-001 SHALL have parameter DATA_W, default 12, SAR result width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, averaged-result FIFO entries (power of two, min 2).
REQ-003 SHALL have one clock and a synchronous, active-high reset. Both are listed below.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  capture enable; 0 = ignore conversions and discard partial window.
REQ-007 avg_log2  input  2  window size N = 2^avg_log2 (1, 2, 4, 8 conversions).
REQ-008 bitout  input  DATA_W  SAR result, valid while conv_done is high.
REQ-009 conv_done  input  1  SAR conversion-complete level from upstream SAR logic.
REQ-010 out_data  output  DATA_W  FIFO head (averaged result).
REQ-011 out_valid  output  1  FIFO non-empty.
REQ-012 out_ready  input  1  consumer accepts out_data this cycle.
REQ-013 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of stored entries.
REQ-014 overflow  output  1  sticky: an averaged result was dropped.
REQ-015 clr_ovf  input  1  clears overflow.

Function
REQ-016 Capture event = conv_done==1 and registered conv_done_q==0, qualified by en==1. Exactly one capture per conv_done rising edge, regardless of high duration.
REQ-017 Window: sample counter cnt (0..7), accumulator acc of DATA_W+3 bits, latched window size k.
REQ-018 At a capture with cnt==0: k <= avg_log2. Changes to avg_log2 mid-window SHALL be ignored until the next window.
REQ-019 At a non-final capture (cnt < 2^k-1): acc <= acc + bitout and cnt <= cnt+1.
REQ-020 At the final capture (cnt == 2^k-1): result = (acc + bitout) >> k, truncated. The result is pushed to the FIFO on the same edge, and acc <= 0, cnt <= 0.
REQ-021 With k==0, every capture is final. Result equals bitout unchanged.
REQ-022 Latency: out_valid rises in the cycle immediately after the edge-detect cycle of the final capture, when the FIFO was empty.
REQ-023 en==0 SHALL clear acc and cnt each cycle. conv_done_q still tracks conv_done, so a rising edge that occurs while en==0 is never captured later.
REQ-024 FIFO: out_data = head entry. A pop occurs when out_valid && out_ready. out_data and out_valid are driven from registered state only (no combinational path from inputs).
REQ-025 Push and pop on the same edge with the FIFO non-empty: both occur and fifo_count is unchanged. This holds when the FIFO is full.
REQ-026 Push when full with no pop: the new result is dropped, FIFO contents are unchanged, and overflow <= 1.
REQ-027 Pop when empty SHALL have no effect. Read/write pointers wrap modulo FIFO_DEPTH.
REQ-028 overflow stays set until clr_ovf==1. If clr_ovf and a new drop occur on the same edge, overflow ends at 1.
REQ-029 Arithmetic SHALL be unsigned. acc SHALL never overflow: max 8 × (2^DATA_W − 1) fits in DATA_W+3 bits.

Reset
REQ-030 Reset SHALL set acc=0, cnt=0, k=0, FIFO pointers=0, fifo_count=0, out_valid=0, out_data=0, overflow=0, conv_done_q=1.
REQ-031 Setting conv_done_q=1 at reset prevents a spurious capture if conv_done is already high when reset is released.
REQ-032 Reset asserted mid-window SHALL discard the partial window and all FIFO contents. Reset SHALL take priority over every other input on that edge.

Verification
REQ-033 Bench: avg_log2=0, en=1, out_ready=1; one conv_done pulse with bitout=0xABC -> out_data=0xABC, out_valid high exactly one cycle after edge detect, fifo_count returns to 0.
REQ-034 Bench: avg_log2=2, four conversions 0x100, 0x101, 0x102, 0x105 -> single result 0x102 (sum 0x408 >> 2); no push after the first three conversions.
REQ-035 Bench: out_ready=0, avg_log2=0, six conversions 1..6 -> fifo_count=4, overflow=1, outputs pop in order 1, 2, 3, 4; clr_ovf pulse -> overflow=0.
REQ-036 Bench: FIFO full with out_ready=1 while the final capture occurs -> push and pop on the same edge, fifo_count stays 4, overflow stays 0.
REQ-037 Bench: conv_done held high for 10 cycles -> exactly one capture. Reset while conv_done is high, then release -> no capture until the next rising edge.
REQ-038 Bench: avg_log2=3, reset after 5 captures, then 8 conversions of 0xFFF -> result 0xFFF; no contribution from the pre-reset samples.
